// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_phy_pkg
//  Purpose  : Shared PHY definitions: the default COM (K28.5) symbol value and
//             the link-training state type used by the serializer.
//  Contents : COM_BYTE_DEFAULT  - 8-bit idle/sync symbol
//             link_state_e      - SYNC / LINK link state
//  Revision : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    // K28.5 comma symbol; used both as sync pattern and as idle fill.
    localparam logic [7:0] COM_BYTE_DEFAULT = 8'hBC;

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_LINK = 1'b1
    } link_state_e;

endpackage : pcie_phy_pkg
`default_nettype wire

// File: rtl/par_to_serial_if.sv
`default_nettype none
// ============================================================================
//  Module   : par_to_serial_if
//  Purpose  : Byte-in / bit-out handshake bundle of the parallel-to-serial
//             converter.
//  Signals  : data_in    [WIDTH] parallel byte offered by the source
//             valid_in   [1]     data_in holds a byte to send
//             ready_out  [1]     serializer accepts a byte on this edge
//             data_out   [1]     serial bit stream, MSB first
//             active_out [1]     current symbol on data_out is data, not COM
//             synced_out [1]     link has finished its sync sequence
//  Modports : master - byte source / serial sink (testbench or upstream)
//             slave  - the serializer
//  Revision : 1.0 - initial release
// ============================================================================
interface par_to_serial_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic             active_out;
    logic             synced_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  active_out,
        input  synced_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output active_out,
        output synced_out
    );

endinterface : par_to_serial_if
`default_nettype wire

// File: rtl/par_to_serial.sv
`default_nettype none
// ============================================================================
//  Module   : par_to_serial
//  Purpose  : Serializes parallel bytes onto a 1-bit stream, MSB first.
//             After reset it emits SYNC_COMS COM symbols, then enters LINK
//             and accepts one byte per 8-bit symbol slot; empty slots are
//             filled with COM.
//  Ports    : clk_32f - bit-rate clock, all flops on its rising edge
//             reset   - synchronous, active-high reset
//             bus     - par_to_serial_if.slave (data_in, valid_in,
//                       ready_out, data_out, active_out, synced_out)
//  Revision : 1.0 - initial release
// ============================================================================
module par_to_serial
    import pcie_phy_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] COM_BYTE  = WIDTH'(COM_BYTE_DEFAULT),
    parameter int               SYNC_COMS = 4
) (
    input  wire logic        clk_32f,
    input  wire logic        reset,
    par_to_serial_if.slave   bus
);

    localparam int CNT_W = $clog2(SYNC_COMS + 1);

    logic [2:0]       bit_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] com_cnt_q;
    link_state_e      state_q;
    logic             active_q;
    logic             synced_q;

    logic             boundary;
    logic             accept;

    // A symbol slot ends when the bit counter reaches 7; the next symbol is
    // loaded on that edge.
    assign boundary = (bit_cnt_q == 3'd7);

    // ready is decoded purely from registers so the source sees a stable
    // acceptance window for the whole boundary cycle.
    assign bus.ready_out = (state_q == ST_LINK) && boundary;
    assign accept        = bus.valid_in && bus.ready_out;

    assign bus.data_out   = shift_q[WIDTH-1];
    assign bus.active_out = active_q;
    assign bus.synced_out = synced_q;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            com_cnt_q <= '0;
            state_q   <= ST_SYNC;
            active_q  <= 1'b0;
            synced_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;

            if (boundary) begin
                // accept is never true in SYNC, so SYNC always loads COM.
                if (accept) begin
                    shift_q  <= bus.data_in;
                    active_q <= 1'b1;
                end else begin
                    shift_q  <= COM_BYTE;
                    active_q <= 1'b0;
                end

                if (state_q == ST_SYNC) begin
                    com_cnt_q <= com_cnt_q + CNT_W'(1);
                    // This boundary loads the last sync COM.
                    if (com_cnt_q == CNT_W'(SYNC_COMS - 1)) begin
                        state_q  <= ST_LINK;
                        synced_q <= 1'b1;
                    end
                end
            end else begin
                shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule : par_to_serial
`default_nettype wire

// File: tb/tb_par_to_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_par_to_serial
//  Purpose  : Self-checking bench for par_to_serial. A driver issues bytes per
//             8-bit symbol slot and pushes the expected per-cycle outputs
//             into a scoreboard queue; a monitor pops and compares one entry
//             on every falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_par_to_serial;

    localparam int         SYNC_COMS = 4;
    localparam logic [7:0] COM       = 8'hBC;

    typedef struct {
        logic d;
        logic act;
        logic syn;
        logic rdy;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   mon_en = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   e     = 0;   // cycle index since the last reset edge
    exp_t exp_q[$];

    par_to_serial_if #(.WIDTH(8)) bus ();

    par_to_serial #(
        .WIDTH    (8),
        .COM_BYTE (COM),
        .SYNC_COMS(SYNC_COMS)
    ) dut (
        .clk_32f(clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    // Expected outputs for the 8 cycles following the edge that loads sym.
    // Cycle k after reset: synced once k >= 8*SYNC_COMS; ready during the
    // cycle preceding any boundary numbered above SYNC_COMS.
    task automatic push_sym(input logic [7:0] sym, input logic act, input int base);
        for (int i = 0; i < 8; i++) begin
            exp_t x;
            int   k;
            k     = base + i;
            x.d   = sym[7-i];
            x.act = act;
            x.syn = (k >= 8 * SYNC_COMS);
            x.rdy = (((k + 1) % 8) == 0) && (((k + 1) / 8) > SYNC_COMS);
            exp_q.push_back(x);
        end
    endtask

    // Drive inputs for one cycle; when the coming edge is a boundary, record
    // the symbol the link must carry next.
    task automatic cycle(input logic v, input logic [7:0] d);
        int b;
        bus.valid_in = v;
        bus.data_in  = d;
        b = (e + 1) / 8;
        if (((e + 1) % 8) == 0) begin
            if (b <= SYNC_COMS) push_sym(COM, 1'b0, e + 1);
            else if (v)         push_sym(d, 1'b1, e + 1);
            else                push_sym(COM, 1'b0, e + 1);
        end
        @(posedge clk);
        #1;
        e++;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] r;
        r = 8'($urandom);
        if ($urandom_range(0, 7) == 0) r = COM;
        return r;
    endfunction

    // One 8-cycle symbol slot: noise on the 7 non-boundary cycles, then the
    // chosen valid/data on the boundary cycle.
    task automatic slot(input logic bv, input logic [7:0] bd, input bit sync_hold);
        for (int i = 0; i < 7; i++) begin
            if (sync_hold) cycle(1'b1, 8'h3C);
            else           cycle(1'($urandom_range(0, 1)), rnd_byte());
        end
        cycle(bv, bd);
    endtask

    task automatic restart_after_reset_edge();
        reset = 1'b0;
        e     = 0;
        push_sym(8'h00, 1'b0, 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underrun at t=%0t: got empty queue expected entry", $time);
            end else begin
                x = exp_q.pop_front();
                check("data_out",   bus.data_out,   x.d);
                check("active_out", bus.active_out, x.act);
                check("synced_out", bus.synced_out, x.syn);
                check("ready_out",  bus.ready_out,  x.rdy);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog at t=%0t: got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        restart_after_reset_edge();
        mon_en = 1'b1;

        // Session 1: directed slots.
        for (int j = 0; j < SYNC_COMS; j++) slot(1'b1, 8'h3C, 1'b1); // held valid during SYNC
        slot(1'b0, 8'h00, 1'b0);                                      // idle fill
        slot(1'b1, 8'hA5, 1'b0);
        slot(1'b0, 8'h00, 1'b0);
        slot(1'b1, 8'h01, 1'b0);                                      // back-to-back
        slot(1'b1, 8'hFF, 1'b0);
        slot(1'b1, 8'h80, 1'b0);
        slot(1'b1, 8'hBC, 1'b0);                                      // data equal to COM
        for (int j = 0; j < 19; j++) slot(1'($urandom_range(0, 1)), rnd_byte(), 1'b0);
        slot(1'b1, 8'hF0, 1'b0);

        // Four bits of F0 go out, then reset lands while bit 3 is on the line.
        for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), rnd_byte());
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        reset        = 1'b1;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        restart_after_reset_edge();

        // Session 2: fully random, including valid toggling during SYNC.
        for (int j = 0; j < 40; j++) slot(1'($urandom_range(0, 1)), rnd_byte(), 1'b0);

        bus.valid_in = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain at t=%0t: got %0d entries left expected 0", $time, exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_par_to_serial
`default_nettype wire

// File: doc/par_to_serial.md
PAR_TO_SERIAL -- requirements
Module: par_to_serial

Interface
REQ-001 Parameter WIDTH, default 8: parallel byte width in bits.
REQ-002 Parameter COM_BYTE, default 8'hBC: idle/sync symbol (K28.5 COM).
REQ-003 Parameter SYNC_COMS, default 4: COM symbols sent after reset before data is accepted.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_32f  input  1  bit-rate clock; all flops on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  WIDTH  parallel byte (clk_4f-rate data domain, sampled on clk_32f).
REQ-008 valid_in  input  1  data_in holds a byte to send.
REQ-009 ready_out  output  1  block accepts a byte on this edge.
REQ-010 data_out  output  1  serial bit stream, MSB first.
REQ-011 active_out  output  1  the symbol currently on data_out is data, not COM.
REQ-012 synced_out  output  1  link in LINK state.

Function
REQ-013 The bit counter bit_cnt SHALL be 3 bits, increment every cycle, and wrap 7->0; a "boundary" is any edge where bit_cnt==7.
REQ-014 At a non-boundary edge, the shift register SHALL shift left by one, filling with 0.
REQ-015 At a boundary edge, the shift register SHALL load the next symbol: data_in if accepted, else COM_BYTE.
REQ-016 data_out SHALL equal shift register MSB (registered, no combinational path from inputs).
REQ-017 Latency: bit WIDTH-1 of an accepted byte SHALL appear on data_out in the cycle after the accepting edge; remaining bits follow on consecutive cycles, MSB first.
REQ-018 States: SYNC, LINK; SYNC is entered on reset.
REQ-019 In SYNC, every boundary SHALL load COM_BYTE and increment com_cnt (width clog2(SYNC_COMS+1)).
REQ-020 The boundary that loads the SYNC_COMS-th COM SHALL move state to LINK; synced_out rises the cycle after.
REQ-021 ready_out SHALL be 1 only when state==LINK and bit_cnt==7, combinationally from registers.
REQ-022 A byte is accepted iff valid_in && ready_out at an edge; valid_in and data_in are ignored otherwise.
REQ-023 In LINK, a boundary with valid_in==0 SHALL load COM_BYTE (idle fill), no byte lost or duplicated.
REQ-024 active_out SHALL be registered at each boundary: 1 if a data byte was loaded, 0 if COM; held for the 8 bit cycles.
REQ-025 Back-to-back acceptance at consecutive boundaries SHALL produce a gapless serial stream.
REQ-026 A data byte equal to COM_BYTE SHALL be sent unchanged with active_out=1.
REQ-027 LINK SHALL persist until reset; no other exit.

Reset
REQ-028 While reset==1 at an edge: bit_cnt=0, shift register=0, com_cnt=0, state=SYNC, data_out=0, active_out=0, synced_out=0, ready_out=0.
REQ-029 Reset asserted mid-symbol SHALL abort the symbol on the next edge; sync restarts from zero COMs.
REQ-030 After reset release, first boundary SHALL be the 8th edge (data_out=0 for 8 cycles, then first COM).

Structure
REQ-031 COM_BYTE value and the SYNC/LINK state enum SHALL live in shared package pcie_phy_pkg.
REQ-032 No sub-module; counter, shift register and FSM are in one module.

Verification
REQ-033 Reset release, valid_in=0 -> 8 zero bits, then 4x 10111100, synced_out=1 after 4th COM load, ready_out first high at 5th boundary.
REQ-034 In LINK, data_in=8'hA5 valid at boundary -> data_out 1,0,1,0,0,1,0,1 next 8 cycles, active_out=1 throughout.
REQ-035 Bytes 8'h01,8'hFF,8'h80 at three consecutive boundaries -> 24 contiguous bits, no COM between, active_out=1 for 24 cycles.
REQ-036 valid_in held high during SYNC with data_in=8'h3C -> no acceptance, only COMs output, ready_out stays 0.
REQ-037 Reset pulsed at bit 3 of data byte 8'hF0 in LINK -> next edge all outputs 0, full 4-COM resync repeats.
REQ-038 Data byte 8'hBC accepted -> 10111100 on data_out with active_out=1, distinguishing from idle COM.
